// File: rtl/ysyx_220066_mem_stage.sv
// MEM stage of the ysyx_220066 RV64 core: one data-bus transaction per instruction, store alignment, load extension.
// Optional bus-wait timeout enabled by defining YSYX_220066_MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module ysyx_220066_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int XLEN           = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            block,
  input  logic            valid_in,
  input  logic            error_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      MemOp_in,
  input  logic            MemRd_in,
  input  logic            MemWr_in,
  input  logic            RegWr_in,
  input  logic            done_in,
  output logic            mem_req,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            RegWr,
  output logic            done,
  output logic            error
);

  if (XLEN != 64) begin : g_bad_xlen
    $error("ysyx_220066_mem_stage supports XLEN = 64 only");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a[1:0] != 2'b00);
      2'b11:   misaligned = (a != 3'b000);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] op, input logic [XLEN-1:0] raw);
    case (op)
      3'b000:  load_fmt = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010:  load_fmt = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, raw[15:0]};
      3'b110:  load_fmt = {{(XLEN-32){1'b0}}, raw[31:0]};
      default: load_fmt = raw;
    endcase
  endfunction

  state_t            state;
  logic              vld_p0;
  logic [XLEN-1:0]   pc_p0, addr_p0, sdata_p0;
  logic [4:0]        rd_p0;
  logic [2:0]        op_p0;
  logic              rdm_p0, wrm_p0, regwr_p0, done_p0, err_p0;
  logic [XLEN-1:0]   rdata_p1;
  logic              rerr_p1;
  logic              advance, start_req, mis_p0, err_out;
  logic [XLEN-1:0]   raw_p1;
  logic [7:0]        mask_base;

  assign busy      = (state == REQ);
  assign advance   = ~block & ~busy;
  assign start_req = valid_in & (MemRd_in | MemWr_in) & ~error_in & ~misaligned(MemOp_in[1:0], result_in[2:0]);

`ifdef YSYX_220066_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif

  // Stage 0: latch EX outputs; stage 1: capture the bus response
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vld_p0   <= 1'b0;
      rdm_p0   <= 1'b0;
      wrm_p0   <= 1'b0;
      regwr_p0 <= 1'b0;
      done_p0  <= 1'b0;
      err_p0   <= 1'b0;
      rerr_p1  <= 1'b0;
      pc_p0    <= '0;
      addr_p0  <= '0;
      sdata_p0 <= '0;
      rd_p0    <= '0;
      op_p0    <= '0;
`ifdef YSYX_220066_MEM_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else if (advance) begin
      vld_p0   <= valid_in;
      pc_p0    <= pc_in;
      addr_p0  <= result_in;
      sdata_p0 <= store_data_in;
      rd_p0    <= rd_in;
      op_p0    <= MemOp_in;
      rdm_p0   <= MemRd_in;
      wrm_p0   <= MemWr_in;
      regwr_p0 <= RegWr_in;
      done_p0  <= done_in;
      err_p0   <= error_in;
      rerr_p1  <= 1'b0;
      state    <= start_req ? REQ : IDLE;
`ifdef YSYX_220066_MEM_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else if (state == REQ) begin
      if (mem_ready) begin
        state    <= DONE;
        rdata_p1 <= mem_rdata;
        rerr_p1  <= mem_err;
      end
`ifdef YSYX_220066_MEM_TIMEOUT_EN
      else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state   <= DONE;
        rerr_p1 <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
`endif
    end
  end

  assign mis_p0    = (rdm_p0 | wrm_p0) & misaligned(op_p0[1:0], addr_p0[2:0]);
  assign raw_p1    = rdata_p1 >> {addr_p0[2:0], 3'b000};
  assign err_out   = err_p0 | mis_p0 | rerr_p1;

  always_comb begin
    case (op_p0[1:0])
      2'b00:   mask_base = 8'h01;
      2'b01:   mask_base = 8'h03;
      2'b10:   mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

  assign mem_req   = busy;
  assign mem_wen   = wrm_p0;
  assign mem_addr  = {addr_p0[XLEN-1:3], 3'b000};
  assign mem_wdata = sdata_p0 << {addr_p0[2:0], 3'b000};
  assign mem_wmask = mask_base << addr_p0[2:0];

  assign valid  = vld_p0 & ~busy;
  assign pc     = pc_p0;
  assign rd     = rd_p0;
  assign result = rdm_p0 ? load_fmt(op_p0, raw_p1) : addr_p0;
  assign error  = err_out;
  assign RegWr  = regwr_p0 & ~err_out;
  assign done   = done_p0;

endmodule

// File: tb/tb_ysyx_220066_mem_stage.sv
// Scoreboard bench for ysyx_220066_mem_stage: expected WB results queued at issue, checked at retirement.
module tb_ysyx_220066_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst, block, valid_in, error_in;
  logic [63:0] pc_in, result_in, store_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  MemOp_in;
  logic        MemRd_in, MemWr_in, RegWr_in, done_in;
  logic        mem_req, mem_wen, mem_ready, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy, valid, RegWr, done, error;
  logic [63:0] pc, result;
  logic [4:0]  rd;

  ysyx_220066_mem_stage #(.TIMEOUT_CYCLES(TMO), .XLEN(64)) dut (
    .clk(clk), .rst(rst), .block(block), .valid_in(valid_in), .error_in(error_in),
    .pc_in(pc_in), .result_in(result_in), .store_data_in(store_data_in), .rd_in(rd_in),
    .MemOp_in(MemOp_in), .MemRd_in(MemRd_in), .MemWr_in(MemWr_in), .RegWr_in(RegWr_in),
    .done_in(done_in), .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .busy(busy), .valid(valid), .pc(pc), .result(result), .rd(rd),
    .RegWr(RegWr), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        regwr;
    logic        err;
    logic        done;
    bit          chk_res;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Retire one instruction whenever WB would accept it on the coming edge
  always @(negedge clk) begin
    if (!rst && valid && !block) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_pc", pc, e.pc);
        check("wb_rd", 64'(rd), 64'(e.rd));
        check("wb_regwr", 64'(RegWr), 64'(e.regwr));
        check("wb_error", 64'(error), 64'(e.err));
        check("wb_done", 64'(done), 64'(e.done));
        if (e.chk_res) check("wb_result", result, e.result);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] p, input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] r, input logic [2:0] op,
                       input logic rdm, input logic wrm, input logic rw);
    valid_in = 1'b1; error_in = 1'b0; pc_in = p; result_in = res; store_data_in = sd;
    rd_in = r; MemOp_in = op; MemRd_in = rdm; MemWr_in = wrm; RegWr_in = rw; done_in = 1'b0;
  endtask

  task automatic idle_in;
    valid_in = 1'b0; MemRd_in = 1'b0; MemWr_in = 1'b0; RegWr_in = 1'b0; done_in = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [63:0] baddr;
  } st_t;

  st_t stores[4] = '{
    '{3'b001, 64'h8000_0006, 64'h1234,               8'hC0, 64'h1234_0000_0000_0000, 64'h8000_0000},
    '{3'b000, 64'h8000_0005, 64'hAB,                 8'h20, 64'h0000_AB00_0000_0000, 64'h8000_0000},
    '{3'b010, 64'h8000_0004, 64'hDEAD_BEEF,          8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h8000_0000},
    '{3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h8000_0008}
  };

  initial begin
    rst = 1'b1; block = 1'b0; error_in = 1'b0; pc_in = '0; result_in = '0; store_data_in = '0;
    rd_in = '0; MemOp_in = '0; mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    idle_in();
    tick(); tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wen", 64'(mem_wen), 64'd0);
    check("rst_regwr", 64'(RegWr), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_pc", pc, 64'd0);
    rst = 1'b0;
    tick();

    // lb with sign extension, two bus wait cycles
    drive(64'h1000, 64'h8000_0003, 64'd0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b1);
    sb.push_back('{64'h1000, 64'hFFFF_FFFF_FFFF_FF80, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1});
    tick(); idle_in();
    check("lb_busy1", 64'(busy), 64'd1);
    check("lb_req", 64'(mem_req), 64'd1);
    check("lb_addr", mem_addr, 64'h8000_0000);
    check("lb_wen", 64'(mem_wen), 64'd0);
    check("lb_valid_busy", 64'(valid), 64'd0);
    tick();
    check("lb_busy2", 64'(busy), 64'd1);
    mem_ready = 1'b1; mem_rdata = 64'h0000_0000_80FF_0000;
    tick();
    mem_ready = 1'b0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    check("lb_busy_done", 64'(busy), 64'd0);
    check("lb_req_done", 64'(mem_req), 64'd0);
    check("lb_valid", 64'(valid), 64'd1);
    tick();
    check("lb_valid_once", 64'(valid), 64'd0);

    // stores: lane shift, byte strobes, aligned address
    foreach (stores[i]) begin
      drive(64'h1100 + 64'(i), stores[i].addr, stores[i].data, 5'd0, stores[i].op, 1'b0, 1'b1, 1'b0);
      sb.push_back('{64'h1100 + 64'(i), stores[i].addr, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      tick(); idle_in();
      check("st_req", 64'(mem_req), 64'd1);
      check("st_wen", 64'(mem_wen), 64'd1);
      check("st_wmask", 64'(mem_wmask), 64'(stores[i].mask));
      check("st_wdata", mem_wdata, stores[i].wdata);
      check("st_addr", mem_addr, stores[i].baddr);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
    end

    // bus error on an aligned lw
    drive(64'h1200, 64'h8000_0008, 64'd0, 5'd8, 3'b010, 1'b1, 1'b0, 1'b1);
    sb.push_back('{64'h1200, 64'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0});
    tick(); idle_in();
    mem_ready = 1'b1; mem_err = 1'b1;
    tick();
    mem_ready = 1'b0; mem_err = 1'b0;
    tick();

    // misaligned lw: no bus request, error out next cycle
    drive(64'h2000, 64'h8000_0002, 64'd0, 5'd7, 3'b010, 1'b1, 1'b0, 1'b1);
    sb.push_back('{64'h2000, 64'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0});
    tick(); idle_in();
    check("mis_req", 64'(mem_req), 64'd0);
    check("mis_busy", 64'(busy), 64'd0);
    check("mis_valid", 64'(valid), 64'd1);
    tick();

    // non-memory op held by downstream stall
    drive(64'h3000, 64'h42, 64'd0, 5'd9, 3'b000, 1'b0, 1'b0, 1'b1);
    done_in = 1'b1;
    sb.push_back('{64'h3000, 64'h42, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1});
    tick(); idle_in();
    block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("blk_valid", 64'(valid), 64'd1);
      check("blk_result", result, 64'h42);
      check("blk_regwr", 64'(RegWr), 64'd1);
      tick();
    end
    block = 1'b0;
    tick();

    // back-to-back: ld then lhu issued in the DONE cycle
    drive(64'h4000, 64'h8000_0010, 64'd0, 5'd3, 3'b011, 1'b1, 1'b0, 1'b1);
    sb.push_back('{64'h4000, 64'h1122_3344_5566_7788, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1});
    tick(); idle_in();
    mem_ready = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    tick();
    mem_ready = 1'b0;
    drive(64'h4004, 64'h8000_0016, 64'd0, 5'd4, 3'b101, 1'b1, 1'b0, 1'b1);
    sb.push_back('{64'h4004, 64'h8765, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1});
    check("b2b_valid", 64'(valid), 64'd1);
    check("b2b_noreq", 64'(mem_req), 64'd0);
    tick(); idle_in();
    check("b2b_req", 64'(mem_req), 64'd1);
    check("b2b_addr", mem_addr, 64'h8000_0010);
    mem_ready = 1'b1; mem_rdata = 64'h8765_4321_0000_0000;
    tick();
    mem_ready = 1'b0;
    tick();

    // reset in the middle of a transaction, then a stray mem_ready
    drive(64'h5000, 64'h8000_0020, 64'd0, 5'd1, 3'b010, 1'b1, 1'b0, 1'b1);
    tick(); idle_in();
    check("rreq_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rreq_req_after", 64'(mem_req), 64'd0);
    check("rreq_valid_after", 64'(valid), 64'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("stray_valid", 64'(valid), 64'd0);
    check("stray_busy", 64'(busy), 64'd0);
    tick();
    check("stray_valid2", 64'(valid), 64'd0);

`ifdef YSYX_220066_MEM_TIMEOUT_EN
    drive(64'h6000, 64'h8000_0028, 64'd0, 5'd6, 3'b010, 1'b1, 1'b0, 1'b1);
    sb.push_back('{64'h6000, 64'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0});
    tick(); idle_in();
    for (int k = 0; k < TMO; k++) begin
      check("tmo_req", 64'(mem_req), 64'd1);
      tick();
    end
    check("tmo_req_drop", 64'(mem_req), 64'd0);
    check("tmo_error", 64'(error), 64'd1);
    tick();
`endif

    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
